// File: rtl/audio_pwm_modulator_pkg.sv
// -----------------------------------------------------------------------------
// audio_pwm_modulator_pkg
// Shared definitions for the audio PWM modulator: default sample and duty
// widths, and the encoding of the sample-to-duty conversion mode.
// -----------------------------------------------------------------------------
package audio_pwm_modulator_pkg;

    // Default signed sample width and PWM duty resolution.
    localparam int SAMPLE_W_DEF = 16;
    localparam int PWM_BITS_DEF = 8;

    // Conversion mode, sampled together with the audio sample at accept.
    typedef enum logic {
        MODE_MAG    = 1'b0,  // rectified magnitude
        MODE_OFFSET = 1'b1   // offset-binary (bipolar around mid-scale)
    } mode_e;

endpackage : audio_pwm_modulator_pkg

// File: rtl/audio_pwm_modulator_pwm_core.sv
// -----------------------------------------------------------------------------
// pwm_core
// Free-running period counter plus duty comparator. The counter runs
// 0..P-1 with P = 2^PWM_BITS - 1, so a duty of 2^PWM_BITS - 1 keeps the
// output high for the whole period and a duty of 0 keeps it low.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   duty     in   active duty, must only change at a period boundary
//   pwm_out  out  registered (cnt < duty) of the previous cycle
//   wrap     out  high on the last count of the period (cnt == P-1)
// -----------------------------------------------------------------------------
module pwm_core
    import audio_pwm_modulator_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_out,
    output logic                wrap
);

    // Last count value of a period: P-1 = 2^PWM_BITS - 2.
    localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                pwm_q;

    always_comb begin
        wrap  = (cnt_q == CNT_LAST);
        cnt_d = wrap ? '0 : cnt_q + PWM_BITS'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= (cnt_q < duty);
        end
    end

    assign pwm_out = pwm_q;

endmodule : pwm_core

// File: rtl/audio_pwm_modulator.sv
// -----------------------------------------------------------------------------
// audio_pwm_modulator
// Converts signed audio samples into a PWM duty and drives a PWM output.
// A sample is converted at accept time and parked in a one-entry holding
// register; the active duty only reloads from it when the period counter
// wraps, so the duty never changes mid-period.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   sample_in     in   signed two's-complement audio sample
//   sample_valid  in   sample_in is valid this cycle
//   sample_ready  out  holding register empty (0 during reset)
//   mode          in   0 = magnitude, 1 = offset-binary; sampled at accept
//   pwm_out       out  registered PWM drive
//   period_start  out  one-cycle pulse on the first PWM cycle of a period
//
// Legal parameter range: 2 <= PWM_BITS <= SAMPLE_W-1.
// -----------------------------------------------------------------------------
module audio_pwm_modulator
    import audio_pwm_modulator_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                mode,
    output logic                pwm_out,
    output logic                period_start
);

    // Right-shifts that reduce each converted value to PWM_BITS bits.
    localparam int MAG_SHIFT = SAMPLE_W - 1 - PWM_BITS;
    localparam int OFF_SHIFT = SAMPLE_W - PWM_BITS;

    localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Sample conversion
    // ------------------------------------------------------------------
    mode_e               mode_sel;
    logic [SAMPLE_W-1:0] neg_sample;
    logic [SAMPLE_W-2:0] sat_abs;
    logic [SAMPLE_W-1:0] offset_bin;
    logic [PWM_BITS-1:0] new_duty;

    // NOTE: every combinational output gets a default on entry so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mode_sel   = mode_e'(mode);
        neg_sample = ~sample_in + SAMPLE_W'(1);
        sat_abs    = (SAMPLE_W-1)'(sample_in);
        new_duty   = '0;

        // |sample|, with the most negative value clipped to full scale
        // because its magnitude does not fit in SAMPLE_W-1 bits.
        if (sample_in == MOST_NEG) begin
            sat_abs = '1;
        end else if (sample_in[SAMPLE_W-1]) begin
            sat_abs = (SAMPLE_W-1)'(neg_sample);
        end

        // Adding 2^(SAMPLE_W-1) modulo 2^SAMPLE_W is just an MSB flip.
        offset_bin = {~sample_in[SAMPLE_W-1], sample_in[SAMPLE_W-2:0]};

        case (mode_sel)
            MODE_OFFSET: new_duty = PWM_BITS'(offset_bin >> OFF_SHIFT);
            default:     new_duty = PWM_BITS'(sat_abs >> MAG_SHIFT);
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register handshake and active duty
    // ------------------------------------------------------------------
    logic                hold_full_q, hold_full_d;
    logic [PWM_BITS-1:0] hold_duty_q, hold_duty_d;
    logic [PWM_BITS-1:0] act_duty_q, act_duty_d;
    logic                accept;
    logic                wrap;

    assign sample_ready = ~hold_full_q & ~reset;
    assign accept       = sample_valid & sample_ready;

    // An accept needs an empty holding register and a wrap load needs a
    // full one, so the two never compete in the same cycle; an accept on
    // the wrap cycle therefore waits for the next wrap.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_duty_d = hold_duty_q;
        act_duty_d  = act_duty_q;

        if (wrap && hold_full_q) begin
            act_duty_d  = hold_duty_q;
            hold_full_d = 1'b0;
        end

        if (accept) begin
            hold_full_d = 1'b1;
            hold_duty_d = new_duty;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            act_duty_q  <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            act_duty_q  <= act_duty_d;
        end
    end

    // NOTE: the held duty value is qualified by hold_full_q, so it needs no
    // reset; clearing the flag is enough to discard it.
    always_ff @(posedge clk) begin
        hold_duty_q <= hold_duty_d;
    end

    // ------------------------------------------------------------------
    // Period start marker
    // ------------------------------------------------------------------
    // cnt_zero_q is high exactly when the core's counter holds 0: after
    // reset (which clears the counter) and after every wrap. period_start
    // registers it so it lines up with pwm_out, which lags cnt by a cycle.
    logic cnt_zero_q;
    logic period_start_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_zero_q     <= 1'b1;
            period_start_q <= 1'b0;
        end else begin
            cnt_zero_q     <= wrap;
            period_start_q <= cnt_zero_q;
        end
    end

    assign period_start = period_start_q;

    // ------------------------------------------------------------------
    // Counter and comparator
    // ------------------------------------------------------------------
    pwm_core #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_core (
        .clk     (clk),
        .reset   (reset),
        .duty    (act_duty_q),
        .pwm_out (pwm_out),
        .wrap    (wrap)
    );

endmodule : audio_pwm_modulator

// File: tb/tb_audio_pwm_modulator.sv
// -----------------------------------------------------------------------------
// tb_audio_pwm_modulator
// Scoreboard bench: the driver keeps a period-level model of the block (cycle
// index since reset release, one pending sample slot, active duty) and pushes
// the expected duty of every upcoming PWM period into a queue. A separate
// monitor pops one entry per period_start pulse and checks the whole period
// of pwm_out against it.
// -----------------------------------------------------------------------------
module tb_audio_pwm_modulator;
    import audio_pwm_modulator_pkg::*;

    localparam int SW = 16;
    localparam int PB = 8;
    localparam int P  = (1 << PB) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic          mode;
    logic          pwm_out;
    logic          period_start;

    always #5 clk = ~clk;

    audio_pwm_modulator #(
        .SAMPLE_W (SW),
        .PWM_BITS (PB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mode         (mode),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Duty from the conversion rules, in plain integer arithmetic.
    function automatic int ref_duty(input logic [SW-1:0] s, input bit m);
        int sv, a;
        sv = int'($signed(s));
        if (m == MODE_MAG) begin
            a = (sv < 0) ? -sv : sv;
            if (a > (1 << (SW-1)) - 1) a = (1 << (SW-1)) - 1;
            return a >> (SW - 1 - PB);
        end
        return (sv + (1 << (SW-1))) >> (SW - PB);
    endfunction

    // ------------------------------------------------------------------
    // Reference model state (driver side)
    // ------------------------------------------------------------------
    int n;          // cycle index since reset release; cnt = n % P
    bit m_full;     // a sample is waiting for the next period
    int m_pending;
    int m_active;
    int exp_q[$];   // expected duty of each upcoming period
    bit mon_en = 1'b0;

    // One clock cycle: drive inputs at the falling edge, check ready, and
    // advance the model to the next falling edge.
    task automatic step(input bit v, input logic [SW-1:0] s, input bit m, output bit acc);
        bit exp_ready, wrap_load;
        int cnt;
        sample_valid = v;
        sample_in    = s;
        mode         = m;
        #1;
        exp_ready = !m_full;
        check("sample_ready", sample_ready, exp_ready);
        acc       = v && exp_ready;
        cnt       = n % P;
        wrap_load = (cnt == P - 1) && m_full;
        if (wrap_load) begin
            m_active = m_pending;
            m_full   = 1'b0;
        end
        if (acc) begin
            m_full    = 1'b1;
            m_pending = ref_duty(s, m);
        end
        if (cnt == P - 1) exp_q.push_back(m_active);
        n++;
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        bit acc;
        for (int i = 0; i < cycles; i++) begin
            // Junk data with valid low must never be taken.
            step(1'b0, SW'($urandom), 1'($urandom), acc);
        end
    endtask

    // Hold valid until the model accepts, with a bounded wait.
    task automatic send(input logic [SW-1:0] s, input bit m);
        bit acc   = 1'b0;
        int guard = 0;
        while (!acc && guard < 2 * P + 10) begin
            step(1'b1, s, m, acc);
            guard++;
        end
        sample_valid = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    // Called at a falling edge: reset for three rising edges, then release.
    task automatic do_reset();
        bit acc;
        reset        = 1'b1;
        sample_valid = 1'b0;
        mon_en       = 1'b0;
        @(negedge clk);
        check("reset_pwm_out", pwm_out, 0);
        check("reset_period_start", period_start, 0);
        check("reset_sample_ready", sample_ready, 0);
        @(negedge clk);
        check("reset_pwm_out_hold", pwm_out, 0);
        @(negedge clk);
        exp_q.delete();
        m_full    = 1'b0;
        m_active  = 0;
        m_pending = 0;
        n         = 0;
        reset     = 1'b0;
        exp_q.push_back(0);
        mon_en    = 1'b1;
        check("release_period_start_c0", period_start, 0);
        step(1'b0, '0, 1'b0, acc);
        check("release_period_start_c1", period_start, 1);
    endtask

    // ------------------------------------------------------------------
    // Monitor: one scoreboard entry per PWM period
    // ------------------------------------------------------------------
    int  mon_duty;
    int  mon_pos;
    int  mon_high;
    int  mon_shape_err;
    bit  mon_in_period   = 1'b0;
    int  periods_checked = 0;

    always @(posedge clk) begin
        #1;
        if (!mon_en) begin
            mon_in_period = 1'b0;
        end else begin
            if (period_start === 1'b1) begin
                if (mon_in_period) begin
                    check("period_length", mon_pos, P);
                    check("period_high_cycles", mon_high, mon_duty);
                    check("period_shape_errors", mon_shape_err, 0);
                    periods_checked++;
                end
                if (exp_q.size() == 0) begin
                    check("expected_period_available", exp_q.size(), 1);
                    mon_in_period = 1'b0;
                end else begin
                    mon_duty      = exp_q.pop_front();
                    mon_pos       = 0;
                    mon_high      = 0;
                    mon_shape_err = 0;
                    mon_in_period = 1'b1;
                end
            end
            if (mon_in_period) begin
                if (pwm_out === 1'b1) mon_high++;
                if (pwm_out !== ((mon_pos < mon_duty) ? 1'b1 : 1'b0)) mon_shape_err++;
                mon_pos++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [SW-1:0] corners [5] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8001};

    initial begin
        bit            acc;
        int            guard;
        logic [SW-1:0] s;
        bit            m;

        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        mode         = 1'b0;
        do_reset();
        idle(3);

        // Magnitude mode, both full-scale extremes -> 255.
        send(16'h8000, MODE_MAG);
        send(16'h7FFF, MODE_MAG);
        // Magnitude of -16384 -> 128.
        send(16'hC000, MODE_MAG);
        // Offset-binary: mid-scale, bottom, top.
        send(16'h0000, MODE_OFFSET);
        send(16'h8000, MODE_OFFSET);
        send(16'h7FFF, MODE_OFFSET);
        idle(P + 5);

        // Two samples offered within one period: the second waits for the wrap.
        guard = 0;
        while ((n % P) != 20 && guard < 2 * P) begin
            idle(1);
            guard++;
        end
        send(16'h2000, MODE_MAG);
        send(16'h4000, MODE_OFFSET);
        idle(2 * P);

        // Randomised samples with random gaps.
        for (int i = 0; i < 30; i++) begin
            s = SW'($urandom);
            if ($urandom_range(0, 3) == 0) s = corners[$urandom_range(0, 4)];
            m = 1'($urandom);
            send(s, m);
            idle($urandom_range(0, 300));
        end
        idle(P + 5);

        // Reset mid-period with duty 200 active and the holding slot full.
        send(16'h4800, MODE_OFFSET);
        guard = 0;
        while (!(m_active == 200 && !m_full && (n % P) < 50) && guard < 3 * P) begin
            idle(1);
            guard++;
        end
        check("duty200_reached", m_active, 200);
        send(16'h7FFF, MODE_OFFSET);
        guard = 0;
        while ((n % P) != 100 && guard < P) begin
            idle(1);
            guard++;
        end
        check("pwm_high_before_reset", pwm_out, 1);
        do_reset();
        idle(3 * P + 10);

        check("periods_checked_enough", (periods_checked >= 40) ? 1 : 0, 1);
        check("scoreboard_backlog_ok", (exp_q.size() <= 1) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_audio_pwm_modulator
